inst_cache: RTL and testbench
=============================

# inst_cache

Direct-mapped, read-only instruction cache between the instruction unit and the memory controller. It looks up the PC the instruction unit presents and returns the 32-bit instruction the cycle after a hit. On a miss it refills the whole line from the memory controller one word at a time. A pipeline clear aborts an in-flight refill cleanly without corrupting any line.

## Interface
- `IC_IDX_WIDTH`, default 6: log2 of the number of lines (64 lines).
- `BLOCK_WIDTH`, default 2: log2 of the number of words per line (4 words, 16 bytes).
- `clk_in` in 1: the single clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `rdy_in` in 1: global enable; when low, all state and outputs hold.
- `clr_in` in 1: pipeline clear (branch mispredict).
- `iu_to_ic_pc` in 32: fetch address; bits [1:0] ignored.
- `ic_to_iu_rdy` out 1: instruction valid for the current `iu_to_ic_pc`.
- `ic_to_iu_inst` out 32: instruction word.
- `ic_to_mc_en` out 1: word read request, held until accepted.
- `ic_to_mc_addr` out 32: word-aligned read address.
- `mc_to_ic_rdy` in 1: one-cycle pulse; requested word is on `mc_to_ic_data`.
- `mc_to_ic_data` in 32: returned word.

## Operation
- Address split:
  - offset = pc[BLOCK_WIDTH+1:2]
  - index = next IC_IDX_WIDTH bits
  - tag = pc[31:BLOCK_WIDTH+IC_IDX_WIDTH+2]
- Storage: per line one valid bit, one tag, and 2^BLOCK_WIDTH data words. Reset clears every valid bit. Data and tag arrays are not reset.
- States: IDLE, REFILL, DRAIN.
- IDLE, every cycle:
  - Sample `iu_to_ic_pc` into `req_pc`.
  - Hit (valid && tag match): register the data word and set `hit_q`.
  - Miss: clear `hit_q`, latch the line base {tag, index, 0}, reset `fill_cnt` to 0, go to REFILL.
- `ic_to_iu_rdy` = `hit_q` && (`req_pc` == `iu_to_ic_pc`). This combinational qualifier ensures a stale hit is never reported for a changed PC.
- REFILL:
  - Drive `ic_to_mc_en`=1 with `ic_to_mc_addr` = line base + (`fill_cnt` << 2).
  - On `mc_to_ic_rdy`, write `mc_to_ic_data` into data[index][`fill_cnt`] and increment `fill_cnt`.
  - When the last word (`fill_cnt` = 2^BLOCK_WIDTH−1) arrives, set valid and tag for the line, then go to IDLE.
  - `ic_to_mc_en` drops in the same cycle the last word is accepted (the registered output is 0 the following cycle).
- The line's valid bit is cleared when REFILL is entered. A partially filled line is therefore never a hit.
- `clr_in` in IDLE: clear `hit_q`; no other effect.
- `clr_in` in REFILL:
  - If `mc_to_ic_rdy` is also high that cycle, accept the word, then go to DRAIN.
  - Otherwise, drive `ic_to_mc_en`=0 and go to DRAIN.
  - The line stays invalid in both cases.
- DRAIN: exists because the memory controller may still return the word already requested. Wait for one `mc_to_ic_rdy` or for 1 cycle with `ic_to_mc_en` low, whichever the controller contract gives. The decided behaviour: leave DRAIN on `mc_to_ic_rdy`, or immediately if no request was outstanding. Discard the data and go to IDLE.
- `clr_in` has priority over hit/miss evaluation in the same cycle.

## Timing
- Reset values: `ic_to_iu_rdy`=0, `ic_to_iu_inst`=0, `ic_to_mc_en`=0, `ic_to_mc_addr`=0, state=IDLE, `fill_cnt`=0, `hit_q`=0, all valid=0.
- Hit latency: PC presented in cycle N gives `ic_to_iu_rdy`=1 in cycle N+1. A constant PC keeps `ic_to_iu_rdy` high on every following cycle.
- Miss penalty: 1 lookup cycle, then the refill time (sum of the memory latencies of 2^BLOCK_WIDTH words), then 1 re-lookup cycle, then data in the next cycle.
- `rdy_in`=0 freezes the FSM, counters and arrays. Incoming `mc_to_ic_rdy` must not occur while `rdy_in`=0 (memory controller contract).
- Reset asserted mid-refill: returns immediately to the reset state. Stale `mc_to_ic_rdy` pulses arriving in IDLE are ignored.
- Wrap-around: `fill_cnt` is BLOCK_WIDTH bits wide and wraps to 0 on the last word. The address adds the offset to the line base only and never carries into the index.

## Structure
- Shared constants header: state encodings (IC_IDLE/IC_REFILL/IC_DRAIN), default cache geometry, and the address-split macros reused by a future data cache.
- One sub-module is natural: `ic_line_store`, holding the valid/tag/data arrays. It has a read port indexed by (index, offset) and a write port for refill words plus tag/valid commit.

## Test plan
- Reset, then present pc=0x0 with memory returning words 0xA0..0xA3 after 3 cycles each: exactly 4 requests at 0x0, 0x4, 0x8, 0xC. `ic_to_iu_rdy`=1 with inst 0xA0 two cycles after the last word.
- After the line fill, present pc=0x8: `ic_to_iu_rdy`=1 with inst 0xA2 in the next cycle, and no memory request.
- Conflict: fill 0x0, then fetch 0x400 (same index with the defaults), then fetch 0x0 again: a refill occurs at 0x400, then another refill at 0x0.
- `clr_in` after the 2nd word of a refill: no further requests beyond the outstanding one. A subsequent fetch of the same line misses and refills all 4 words.
- PC changes from 0x0 to 0x4 in the hit cycle: `ic_to_iu_rdy` is low for the stale `req_pc`, then high with the word for 0x4 one cycle later.
- Hold `rdy_in`=0 for 5 cycles mid-refill: `ic_to_mc_addr`, `fill_cnt` and the outputs are unchanged, and the refill resumes correctly.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared constants for the instruction cache: FSM encodings, default
// geometry and the address-split width helper.
package inst_cache_pkg;

  // Controller states shared by the FSM and its debug port.
  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_REFILL = 2'd1,
    IC_DRAIN  = 2'd2
  } ic_state_e;

  localparam int IC_ADDR_WIDTH       = 32;
  localparam int IC_DEF_IDX_WIDTH    = 6;
  localparam int IC_DEF_BLOCK_WIDTH  = 2;

  // Tag width left over after the byte, word-offset and index fields.
  function automatic int ic_tag_width(input int idx_w, input int blk_w);
    return IC_ADDR_WIDTH - idx_w - blk_w - 2;
  endfunction

endpackage

// File: rtl/ic_line_store.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Asynchronous read port indexed by (index, offset); write port for
// refill words, a line invalidate, and a tag/valid commit.
module ic_line_store
  import inst_cache_pkg::*;
#(
  parameter int IDX_W = IC_DEF_IDX_WIDTH,
  parameter int BLK_W = IC_DEF_BLOCK_WIDTH,
  parameter int TAG_W = ic_tag_width(IC_DEF_IDX_WIDTH, IC_DEF_BLOCK_WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [BLK_W-1:0] i_rd_off,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [31:0]      o_rd_data,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [BLK_W-1:0] i_wr_off,
  input  logic             i_wr_en,
  input  logic [31:0]      i_wr_data,
  input  logic             i_inv,
  input  logic             i_commit,
  input  logic [TAG_W-1:0] i_commit_tag
);

  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = 1 << BLK_W;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES][WORDS];

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx][i_rd_off];

  // Valid bits: cleared by reset, dropped when a refill starts, set on commit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_inv) begin
      r_valid[i_wr_idx] <= 1'b0;
    end else if (i_commit) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Data words and tags are not reset; the valid bit guards them.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_off] <= i_wr_data;
    end
    if (i_commit) begin
      r_tag[i_wr_idx] <= i_commit_tag;
    end
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache. Hits return the word the
// cycle after lookup; misses refill the whole line one word at a time.
// Memory handshake: ic_to_mc_en/ic_to_mc_addr are registered and held
// until mc_to_ic_rdy pulses for one cycle with the word on mc_to_ic_data;
// the word is consumed in that cycle and the next request (if any) is
// presented from the following cycle. rdy_in low freezes everything.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int IC_IDX_WIDTH = IC_DEF_IDX_WIDTH,
  parameter int BLOCK_WIDTH  = IC_DEF_BLOCK_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clr_in,
  input  logic [31:0]            iu_to_ic_pc,
  output logic                   ic_to_iu_rdy,
  output logic [31:0]            ic_to_iu_inst,
  output logic                   ic_to_mc_en,
  output logic [31:0]            ic_to_mc_addr,
  input  logic                   mc_to_ic_rdy,
  input  logic [31:0]            mc_to_ic_data,
  output ic_state_e              dbg_state_out,
  output logic [BLOCK_WIDTH-1:0] dbg_fill_cnt_out
);

  localparam int TAG_W = ic_tag_width(IC_IDX_WIDTH, BLOCK_WIDTH);
  localparam int HI_W  = TAG_W + IC_IDX_WIDTH;
  localparam logic [BLOCK_WIDTH-1:0] LAST_WORD = '1;

  // Address split of the presented PC.
  logic [TAG_W-1:0]        w_pc_tag;
  logic [IC_IDX_WIDTH-1:0] w_pc_idx;
  logic [BLOCK_WIDTH-1:0]  w_pc_off;
  assign w_pc_tag = iu_to_ic_pc[31 -: TAG_W];
  assign w_pc_idx = iu_to_ic_pc[BLOCK_WIDTH+2 +: IC_IDX_WIDTH];
  assign w_pc_off = iu_to_ic_pc[2 +: BLOCK_WIDTH];

  ic_state_e               r_state, w_state_nxt;
  logic [31:0]             r_req_pc, w_req_pc_nxt;
  logic                    r_hit_q, w_hit_nxt;
  logic [31:0]             r_inst, w_inst_nxt;
  logic [HI_W-1:0]         r_line_hi, w_line_hi_nxt;   // {tag, index} of line being filled
  logic [BLOCK_WIDTH-1:0]  r_fill_cnt, w_cnt_nxt;
  logic                    r_mc_en, w_mc_en_nxt;
  logic [31:0]             r_mc_addr, w_mc_addr_nxt;
  logic                    r_drain_wait, w_drain_wait_nxt; // a word is still owed in DRAIN

  logic [TAG_W-1:0]        w_fill_tag;
  logic [IC_IDX_WIDTH-1:0] w_fill_idx;
  logic [BLOCK_WIDTH-1:0]  w_cnt_inc;
  logic                    w_rd_valid;
  logic [TAG_W-1:0]        w_rd_tag;
  logic [31:0]             w_rd_data;
  logic                    w_hit;
  logic [IC_IDX_WIDTH-1:0] w_wr_idx;
  logic                    w_wr_en, w_inv, w_commit;

  assign w_fill_tag = r_line_hi[HI_W-1 -: TAG_W];
  assign w_fill_idx = r_line_hi[IC_IDX_WIDTH-1:0];
  assign w_cnt_inc  = r_fill_cnt + 1'b1;
  assign w_hit      = w_rd_valid && (w_rd_tag == w_pc_tag);

  ic_line_store #(
    .IDX_W (IC_IDX_WIDTH),
    .BLK_W (BLOCK_WIDTH),
    .TAG_W (TAG_W)
  ) u_store (
    .i_clk        (clk_in),
    .i_rst        (rst_in),
    .i_rd_idx     (w_pc_idx),
    .i_rd_off     (w_pc_off),
    .o_rd_valid   (w_rd_valid),
    .o_rd_tag     (w_rd_tag),
    .o_rd_data    (w_rd_data),
    .i_wr_idx     (w_wr_idx),
    .i_wr_off     (r_fill_cnt),
    .i_wr_en      (w_wr_en),
    .i_wr_data    (mc_to_ic_data),
    .i_inv        (w_inv),
    .i_commit     (w_commit),
    .i_commit_tag (w_fill_tag)
  );

  // Next-state and array-control logic; everything holds while rdy_in is low.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_pc_nxt     = r_req_pc;
    w_hit_nxt        = r_hit_q;
    w_inst_nxt       = r_inst;
    w_line_hi_nxt    = r_line_hi;
    w_cnt_nxt        = r_fill_cnt;
    w_mc_en_nxt      = r_mc_en;
    w_mc_addr_nxt    = r_mc_addr;
    w_drain_wait_nxt = r_drain_wait;
    w_wr_idx         = w_fill_idx;
    w_wr_en          = 1'b0;
    w_inv            = 1'b0;
    w_commit         = 1'b0;
    if (rdy_in) begin
      unique case (r_state)
        IC_IDLE: begin
          w_req_pc_nxt = iu_to_ic_pc;
          w_wr_idx     = w_pc_idx;
          if (clr_in) begin
            w_hit_nxt = 1'b0;
          end else if (w_hit) begin
            w_hit_nxt  = 1'b1;
            w_inst_nxt = w_rd_data;
          end else begin
            // Miss: invalidate the victim now so a partial line never hits.
            w_hit_nxt     = 1'b0;
            w_line_hi_nxt = {w_pc_tag, w_pc_idx};
            w_cnt_nxt     = '0;
            w_inv         = 1'b1;
            w_mc_en_nxt   = 1'b1;
            w_mc_addr_nxt = {w_pc_tag, w_pc_idx, {BLOCK_WIDTH{1'b0}}, 2'b00};
            w_state_nxt   = IC_REFILL;
          end
        end
        IC_REFILL: begin
          if (mc_to_ic_rdy) begin
            w_wr_en       = 1'b1;
            w_cnt_nxt     = w_cnt_inc;
            // Offset field replaced, never added, so no carry into the index.
            w_mc_addr_nxt = {r_line_hi, w_cnt_inc, 2'b00};
          end
          if (clr_in) begin
            w_mc_en_nxt      = 1'b0;
            w_drain_wait_nxt = !mc_to_ic_rdy;
            w_state_nxt      = IC_DRAIN;
          end else if (mc_to_ic_rdy && (r_fill_cnt == LAST_WORD)) begin
            w_commit    = 1'b1;
            w_mc_en_nxt = 1'b0;
            w_state_nxt = IC_IDLE;
          end
        end
        IC_DRAIN: begin
          // Swallow the word already requested before the clear, if any.
          if (!r_drain_wait || mc_to_ic_rdy) begin
            w_drain_wait_nxt = 1'b0;
            w_state_nxt      = IC_IDLE;
          end
        end
        default: w_state_nxt = IC_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= IC_IDLE;
      r_req_pc     <= '0;
      r_hit_q      <= 1'b0;
      r_inst       <= '0;
      r_line_hi    <= '0;
      r_fill_cnt   <= '0;
      r_mc_en      <= 1'b0;
      r_mc_addr    <= '0;
      r_drain_wait <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_pc     <= w_req_pc_nxt;
      r_hit_q      <= w_hit_nxt;
      r_inst       <= w_inst_nxt;
      r_line_hi    <= w_line_hi_nxt;
      r_fill_cnt   <= w_cnt_nxt;
      r_mc_en      <= w_mc_en_nxt;
      r_mc_addr    <= w_mc_addr_nxt;
      r_drain_wait <= w_drain_wait_nxt;
    end
  end

  // A registered hit only counts while the PC is still the one looked up.
  assign ic_to_iu_rdy     = r_hit_q && (r_req_pc == iu_to_ic_pc);
  assign ic_to_iu_inst    = r_inst;
  assign ic_to_mc_en      = r_mc_en;
  assign ic_to_mc_addr    = r_mc_addr;
  assign dbg_state_out    = r_state;
  assign dbg_fill_cnt_out = r_fill_cnt;

endmodule

// File: tb/tb_inst_cache.sv
// Bench for inst_cache: directed fills, a hit-vector table and
// hand-written multi-cycle sequences against a 3-cycle memory model.
module tb_inst_cache;
  import inst_cache_pkg::*;

  localparam int MEM_LAT = 3;

  logic        clk_in, rst_in, rdy_in, clr_in;
  logic [31:0] iu_to_ic_pc;
  logic        ic_to_iu_rdy;
  logic [31:0] ic_to_iu_inst;
  logic        ic_to_mc_en;
  logic [31:0] ic_to_mc_addr;
  logic        mc_to_ic_rdy;
  logic [31:0] mc_to_ic_data;
  ic_state_e   dbg_state_out;
  logic [1:0]  dbg_fill_cnt_out;

  inst_cache dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .clr_in           (clr_in),
    .iu_to_ic_pc      (iu_to_ic_pc),
    .ic_to_iu_rdy     (ic_to_iu_rdy),
    .ic_to_iu_inst    (ic_to_iu_inst),
    .ic_to_mc_en      (ic_to_mc_en),
    .ic_to_mc_addr    (ic_to_mc_addr),
    .mc_to_ic_rdy     (mc_to_ic_rdy),
    .mc_to_ic_data    (mc_to_ic_data),
    .dbg_state_out    (dbg_state_out),
    .dbg_fill_cnt_out (dbg_fill_cnt_out)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  int          last_pulse_cyc = 0;
  int          pulse_cnt = 0;
  logic [31:0] exp_q[$];          // expected memory request addresses, in order
  bit          mem_busy = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory controller model: one request at a time, fixed latency.
  task automatic mem_step();
    mc_to_ic_rdy = 1'b0;
    if (rst_in) begin
      mem_busy = 1'b0;
    end else if (rdy_in) begin
      if (mem_busy) begin
        mem_wait--;
        if (mem_wait == 0) begin
          mc_to_ic_rdy   = 1'b1;
          mc_to_ic_data  = mem_word(mem_addr);
          mem_busy       = 1'b0;
          pulse_cnt++;
          last_pulse_cyc = cyc_n;
        end
      end else if (ic_to_mc_en) begin
        mem_busy = 1'b1;
        mem_wait = MEM_LAT;
        mem_addr = ic_to_mc_addr;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL req_unexpected: got request at %h expected none", ic_to_mc_addr);
        end else begin
          chk("req_addr", ic_to_mc_addr, exp_q.pop_front());
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive inputs just after the edge, then sample at the falling edge.
  task automatic cyc(input logic [31:0] pc, input logic clr, input logic rdy);
    @(posedge clk_in);
    #1;
    cyc_n++;
    iu_to_ic_pc = pc;
    clr_in      = clr;
    rdy_in      = rdy;
    mem_step();
    #4;
  endtask

  task automatic wait_hit(input logic [31:0] pc, input logic [31:0] exp_inst,
                          input string name, input bit chk_lat);
    int n;
    n = 0;
    do begin
      cyc(pc, 1'b0, 1'b1);
      n++;
    end while (!ic_to_iu_rdy && n < 200);
    chk({name, "_rdy"}, 32'(ic_to_iu_rdy), 32'd1);
    chk({name, "_inst"}, ic_to_iu_inst, exp_inst);
    chk({name, "_reqs_left"}, 32'(exp_q.size()), 32'd0);
    if (chk_lat) chk({name, "_lat"}, 32'(cyc_n - last_pulse_cyc), 32'd2);
  endtask

  task automatic fetch_line(input logic [31:0] pc, input logic [31:0] exp_inst, input string name);
    logic [31:0] base;
    base = {pc[31:4], 4'h0};
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(i * 4));
    wait_hit(pc, exp_inst, name, 1'b1);
  endtask

  // ---------------- hit vector table ----------------
  typedef struct {
    logic [31:0] pc;
    logic        clr;
    logic        exp_rdy;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{32'h0,  1'b0, 1'b1, 32'hA0};
    vecs[1] = '{32'h4,  1'b0, 1'b1, 32'hA1};
    vecs[2] = '{32'hC,  1'b0, 1'b1, 32'hA3};
    vecs[3] = '{32'h10, 1'b0, 1'b1, 32'hA4};
    vecs[4] = '{32'h1C, 1'b0, 1'b1, 32'hA7};
    vecs[5] = '{32'h8,  1'b1, 1'b0, 32'h0};
    vecs[6] = '{32'h14, 1'b0, 1'b1, 32'hA5};
    vecs[7] = '{32'h4,  1'b1, 1'b0, 32'h0};

    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; iu_to_ic_pc = '0;
    mc_to_ic_rdy = 1'b0; mc_to_ic_data = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_iu_rdy", 32'(ic_to_iu_rdy), 32'd0);
    chk("rst_inst", ic_to_iu_inst, 32'd0);
    chk("rst_mc_en", 32'(ic_to_mc_en), 32'd0);
    chk("rst_mc_addr", ic_to_mc_addr, 32'd0);
    chk("rst_state", 32'(dbg_state_out), 32'(IC_IDLE));
    chk("rst_fill_cnt", 32'(dbg_fill_cnt_out), 32'd0);
    @(posedge clk_in); #1; rst_in = 1'b0;

    // First fill: requests 0,4,8,C; data two cycles after the last word.
    fetch_line(32'h0, 32'hA0, "fill0");

    // Hit within the filled line, no memory traffic.
    cyc(32'h8, 1'b0, 1'b1);
    chk("pc8_first_rdy", 32'(ic_to_iu_rdy), 32'd0);
    cyc(32'h8, 1'b0, 1'b1);
    chk("pc8_rdy", 32'(ic_to_iu_rdy), 32'd1);
    chk("pc8_inst", ic_to_iu_inst, 32'hA2);
    chk("pc8_en", 32'(ic_to_mc_en), 32'd0);

    fetch_line(32'h10, 32'hA4, "fill10");

    // Table of hit / clear vectors over lines 0x0 and 0x10.
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].pc, vecs[i].clr, 1'b1);
      cyc(vecs[i].pc, 1'b0, 1'b1);
      chk($sformatf("vec%0d_rdy", i), 32'(ic_to_iu_rdy), 32'(vecs[i].exp_rdy));
      if (vecs[i].exp_rdy) chk($sformatf("vec%0d_inst", i), ic_to_iu_inst, vecs[i].exp_inst);
      chk($sformatf("vec%0d_en", i), 32'(ic_to_mc_en), 32'd0);
    end

    // PC changes in the hit cycle: stale hit suppressed, new word next cycle.
    cyc(32'h0, 1'b0, 1'b1);
    cyc(32'h0, 1'b0, 1'b1);
    chk("stale_pre_rdy", 32'(ic_to_iu_rdy), 32'd1);
    cyc(32'h4, 1'b0, 1'b1);
    chk("stale_rdy", 32'(ic_to_iu_rdy), 32'd0);
    cyc(32'h4, 1'b0, 1'b1);
    chk("stale_next_rdy", 32'(ic_to_iu_rdy), 32'd1);
    chk("stale_next_inst", ic_to_iu_inst, 32'hA1);

    // Conflict on index 0: both lines refill in turn.
    fetch_line(32'h400, 32'h1A0, "conf_a");
    fetch_line(32'h0, 32'hA0, "conf_b");

    // Clear after the second word of a refill of line 0x20.
    exp_q.delete();
    exp_q.push_back(32'h20); exp_q.push_back(32'h24); exp_q.push_back(32'h28);
    pulse_cnt = 0;
    n = 0;
    while (pulse_cnt < 2 && n < 100) begin
      cyc(32'h20, 1'b0, 1'b1);
      n++;
    end
    chk("clr_two_words", 32'(pulse_cnt), 32'd2);
    cyc(32'h20, 1'b1, 1'b1);
    cyc(32'h0, 1'b0, 1'b1);
    chk("clr_state_drain", 32'(dbg_state_out), 32'(IC_DRAIN));
    chk("clr_en_low", 32'(ic_to_mc_en), 32'd0);
    repeat (10) cyc(32'h0, 1'b0, 1'b1);
    chk("clr_state_idle", 32'(dbg_state_out), 32'(IC_IDLE));
    chk("clr_no_more_reqs", 32'(exp_q.size()), 32'd0);
    chk("clr_pulses", 32'(pulse_cnt), 32'd3);
    chk("clr_en_after", 32'(ic_to_mc_en), 32'd0);
    chk("clr_hit0_rdy", 32'(ic_to_iu_rdy), 32'd1);
    chk("clr_hit0_inst", ic_to_iu_inst, 32'hA0);
    fetch_line(32'h20, 32'hA8, "refetch20");

    // Freeze with rdy_in low for 5 cycles after the first word of line 0x30.
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h30 + 32'(i * 4));
    pulse_cnt = 0;
    n = 0;
    while (pulse_cnt < 1 && n < 100) begin
      cyc(32'h30, 1'b0, 1'b1);
      n++;
    end
    chk("hold_first_word", 32'(pulse_cnt), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(32'h30, 1'b0, 1'b0);
      chk($sformatf("hold%0d_addr", i), ic_to_mc_addr, 32'h34);
      chk($sformatf("hold%0d_en", i), 32'(ic_to_mc_en), 32'd1);
      chk($sformatf("hold%0d_cnt", i), 32'(dbg_fill_cnt_out), 32'd1);
      chk($sformatf("hold%0d_state", i), 32'(dbg_state_out), 32'(IC_REFILL));
    end
    wait_hit(32'h30, 32'hAC, "hold_resume", 1'b1);

    // Reset in the middle of a refill of line 0x40.
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h40 + 32'(i * 4));
    repeat (6) cyc(32'h40, 1'b0, 1'b1);
    @(posedge clk_in); #1;
    rst_in = 1'b1; iu_to_ic_pc = 32'h0; mc_to_ic_rdy = 1'b0;
    mem_busy = 1'b0;
    exp_q.delete();
    #1;
    chk("mrst_en", 32'(ic_to_mc_en), 32'd0);
    chk("mrst_addr", ic_to_mc_addr, 32'd0);
    chk("mrst_inst", ic_to_iu_inst, 32'd0);
    chk("mrst_iu_rdy", 32'(ic_to_iu_rdy), 32'd0);
    chk("mrst_state", 32'(dbg_state_out), 32'(IC_IDLE));
    chk("mrst_cnt", 32'(dbg_fill_cnt_out), 32'd0);
    @(posedge clk_in); #1; rst_in = 1'b0;
    // All lines invalid again: line 0 must refill.
    fetch_line(32'h0, 32'hA0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
